array_op_sequencer: RTL

- Executes one decoded TPU command at a time: LOAD_WEIGHT, LOAD_INPUT, COMPUTE or STORE.
- Converts each command into a timed burst of single-port unified-buffer accesses and systolic-array strobes.
- Sits between the instruction control FSM, which supplies the command and base address, and the buffer/array datapath.
- Owns the buffer port and exposes a ready/valid command handshake plus a one-cycle done pulse.

---
 rtl/array_op_sequencer_if.sv | 36 +++
 rtl/array_op_sequencer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/array_op_sequencer_if.sv
// Command handshake and buffer/array strobe bundle between the instruction
// controller, the array op sequencer and the buffer/array datapath.
interface array_op_sequencer_if #(
    parameter int unsigned ARRAY_N = 4,
    parameter int unsigned ADDR_W  = 6
) ();
    localparam int unsigned ROW_W = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1;

    logic              cmd_valid;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_ready;
    logic              halt;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              wgt_load;
    logic              in_load;
    logic [ROW_W-1:0]  row_idx;
    logic              array_en;
    logic              res_pop;
    logic              busy;
    logic              done;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, halt,
        input  cmd_ready, mem_en, mem_we, mem_addr, wgt_load, in_load, row_idx,
               array_en, res_pop, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, halt,
        output cmd_ready, mem_en, mem_we, mem_addr, wgt_load, in_load, row_idx,
               array_en, res_pop, busy, done
    );
endinterface

// File: rtl/array_op_sequencer.sv
// Turns one decoded TPU command into a timed burst of unified-buffer accesses
// and systolic-array strobes, with a ready/valid command port and a done pulse.
module array_op_sequencer #(
    parameter int unsigned ARRAY_N        = 4,
    parameter int unsigned ADDR_W         = 6,
    parameter int unsigned COMPUTE_CYCLES = 3 * ARRAY_N - 2
) (
    input logic                 clk,
    input logic                 reset,
    array_op_sequencer_if.slave bus
);
    localparam int unsigned ROW_W     = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1;
    localparam int unsigned MAX_BEATS = (COMPUTE_CYCLES > ARRAY_N) ? COMPUTE_CYCLES : ARRAY_N;
    localparam int unsigned BEAT_W    = $clog2(MAX_BEATS + 1);
    localparam logic [BEAT_W-1:0] LAST_ROW = BEAT_W'(ARRAY_N - 1);
    localparam logic [BEAT_W-1:0] LAST_RUN = BEAT_W'(COMPUTE_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdWgt,
        StRdIn,
        StRun,
        StWrOut,
        StFinish
    } state_e;

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              rd_pending_q, rd_pending_d;
    logic              rd_wgt_q, rd_wgt_d;
    logic [ROW_W-1:0]  rd_row_q, rd_row_d;

    logic accept;
    logic reading;
    logic bursting;

    // halt outranks a new command even in IDLE
    assign accept   = (state_q == StIdle) && bus.cmd_valid && !bus.halt;
    assign reading  = (state_q == StRdWgt) || (state_q == StRdIn);
    assign bursting = reading || (state_q == StWrOut);

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        base_d       = base_q;
        // Read data returns one cycle after the access; a halt kills the
        // strobe for the access issued in the halting cycle.
        rd_pending_d = reading && !bus.halt;
        rd_wgt_d     = (state_q == StRdWgt);
        rd_row_d     = beat_q[ROW_W-1:0];

        if (accept) begin
            base_d = bus.cmd_addr;
            beat_d = '0;
            unique case (bus.cmd_op)
                2'd0: state_d = StRdWgt;
                2'd1: state_d = StRdIn;
                2'd2: state_d = StRun;
                2'd3: state_d = StWrOut;
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle && bus.halt) begin
            state_d = StIdle;
            beat_d  = '0;
        end else begin
            unique case (state_q)
                StRdWgt, StRdIn, StWrOut: begin
                    if (beat_q == LAST_ROW) begin
                        state_d = StFinish;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
                StRun: begin
                    if (beat_q == LAST_RUN) begin
                        state_d = StFinish;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
                StFinish: state_d = StIdle;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            beat_q       <= '0;
            base_q       <= '0;
            rd_pending_q <= 1'b0;
            rd_wgt_q     <= 1'b0;
            rd_row_q     <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            base_q       <= base_d;
            rd_pending_q <= rd_pending_d;
            rd_wgt_q     <= rd_wgt_d;
            rd_row_q     <= rd_row_d;
        end
    end

    always_comb begin
        bus.cmd_ready = (state_q == StIdle);
        bus.busy      = (state_q != StIdle);
        bus.mem_en    = bursting;
        bus.mem_we    = (state_q == StWrOut);
        bus.res_pop   = (state_q == StWrOut);
        bus.mem_addr  = bursting ? base_q + ADDR_W'(beat_q) : '0;
        bus.wgt_load  = rd_pending_q && rd_wgt_q;
        bus.in_load   = rd_pending_q && !rd_wgt_q;
        bus.row_idx   = '0;
        if (rd_pending_q) begin
            bus.row_idx = rd_row_q;
        end else if (state_q == StWrOut) begin
            bus.row_idx = beat_q[ROW_W-1:0];
        end
        bus.array_en  = (state_q == StRun);
        bus.done      = (state_q == StFinish);
    end
endmodule
